cover_hit_collector: RTL and testbench

- Receiving end of the per-point coverage reporting path: each cover point raises `valid` with its constant COVER_INDEX.
- This block collects those one-hot-in-time hit reports into an on-chip hit bitmap and counts first-time hits.
- On request, it streams the bitmap out word by word over a valid/ready interface to the fuzzing or formal harness.
- Sits at top level beside the cover-point instances, one instance per coverage domain (e.g. toggle).

---
 rtl/cover_hit_collector.sv | 196 +++++++++++++++++++
 tb/tb_cover_hit_collector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cover_hit_collector.sv
// Coverage hit collector: captures per-point hit reports into a bitmap, counts first hits,
// and dumps the bitmap word by word. Optional clear-on-read enabled by COVER_CLEAR_ON_DUMP_EN.
module cover_hit_collector #(
    parameter int COVER_TOTAL = 8940,
    parameter int IDX_W       = 14,
    parameter int WORD_W      = 64,
    localparam int NUM_WORDS  = (COVER_TOTAL + WORD_W - 1) / WORD_W,
    localparam int ADDR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hit_valid,
    input  logic [IDX_W-1:0]  hit_index,
    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [WORD_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic [31:0]       new_hit_count,
    output logic              oob_err
);

    localparam int OFF_W = $clog2(WORD_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic {IDLE = 1'b0, DUMP = 1'b1} state_e;

    logic [WORD_W-1:0] bitmap_q [NUM_WORDS];
    logic [WORD_W-1:0] bitmap_d [NUM_WORDS];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [31:0]       count_q, count_d;
    logic              oob_q, oob_d;

    logic              hit_ok_s;
    logic              hit_new_s;
    logic [ADDR_W-1:0] hit_word_s;
    logic [OFF_W-1:0]  hit_bit_s;
    logic [WORD_W-1:0] hit_onehot_s;
    logic              handshake_s;

`ifdef COVER_CLEAR_ON_DUMP_EN
    logic [31:0]       late_q, late_d;
    logic              late_hit_s;
`endif

    // Hit decode: range check, word/bit split, first-hit detection
    always_comb begin
        hit_ok_s     = hit_valid && ({1'b0, hit_index} < (IDX_W + 1)'(COVER_TOTAL));
        hit_word_s   = ADDR_W'(hit_index >> OFF_W);
        hit_bit_s    = hit_index[OFF_W-1:0];
        hit_onehot_s = hit_ok_s ? (WORD_W'(1) << hit_bit_s) : '0;
        hit_new_s    = hit_ok_s && !bitmap_q[hit_word_s][hit_bit_s];
        handshake_s  = valid_q && dump_ready;
    end

    // Next bitmap: a set on the same edge as a clear wins
    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++) begin
`ifdef COVER_CLEAR_ON_DUMP_EN
            bitmap_d[w] = (bitmap_q[w] & ~((handshake_s && addr_q == ADDR_W'(w)) ? data_q : '0))
                        | ((hit_word_s == ADDR_W'(w)) ? hit_onehot_s : '0);
`else
            bitmap_d[w] = bitmap_q[w] | ((hit_word_s == ADDR_W'(w)) ? hit_onehot_s : '0);
`endif
        end
    end

`ifdef COVER_CLEAR_ON_DUMP_EN
    // New hits into words already snapshotted are missed by this dump; they become the post-dump count
    always_comb begin
        late_hit_s = hit_new_s && (state_q == DUMP) && (hit_word_s <= addr_q);
        if (state_q == IDLE && dump_req) begin
            late_d = 32'd0;
        end else if (late_hit_s) begin
            late_d = late_q + 32'd1;
        end else begin
            late_d = late_q;
        end
    end
`endif

    // Saturating first-hit counter and sticky out-of-range flag
    always_comb begin
        count_d = count_q;
        oob_d   = oob_q | (hit_valid && !hit_ok_s);
        if (hit_new_s && count_q != 32'hFFFF_FFFF) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
`ifdef COVER_CLEAR_ON_DUMP_EN
        if (handshake_s && last_q) begin
            count_d = late_d;
        end else begin
            count_d = count_d;
        end
`endif
    end

    // Dump FSM; snapshots read the next-state bitmap so same-edge hits are included
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = DUMP;
                    addr_d  = '0;
                    data_d  = bitmap_d[0];
                    last_d  = (NUM_WORDS == 1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            DUMP: begin
                if (handshake_s && last_q) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (handshake_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                    data_d = bitmap_d[addr_d];
                    last_d = (addr_d == LAST_ADDR);
                end else begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                last_d  = 1'b0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                bitmap_q[w] <= '0;
            end
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= 32'd0;
            oob_q   <= 1'b0;
`ifdef COVER_CLEAR_ON_DUMP_EN
            late_q  <= 32'd0;
`endif
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                bitmap_q[w] <= bitmap_d[w];
            end
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            oob_q   <= oob_d;
`ifdef COVER_CLEAR_ON_DUMP_EN
            late_q  <= late_d;
`endif
        end
    end

    assign dump_valid    = valid_q;
    assign dump_addr     = addr_q;
    assign dump_data     = data_q;
    assign dump_last     = last_q;
    assign busy          = busy_q;
    assign new_hit_count = count_q;
    assign oob_err       = oob_q;

endmodule

// File: tb/tb_cover_hit_collector.sv
// Randomized self-checking bench for cover_hit_collector against a bit-array reference model.
module tb_cover_hit_collector;

    localparam int TOTAL = 8940;
    localparam int NW    = 140;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        hit_valid = 1'b0;
    logic [13:0] hit_index = '0;
    logic        dump_req = 1'b0;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [7:0]  dump_addr;
    logic [63:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic [31:0] new_hit_count;
    logic        oob_err;

    cover_hit_collector dut (
        .clock(clock), .reset(reset), .hit_valid(hit_valid), .hit_index(hit_index),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
        .busy(busy), .new_hit_count(new_hit_count), .oob_err(oob_err)
    );

    always #5 clock = ~clock;

    // Reference model
    bit          bm [TOTAL];
    int          set_cyc [TOTAL];
    int          snap_cyc [NW];
    logic [63:0] dumped [NW];
    int unsigned m_count;
    bit          m_oob;
    bit          m_dumping;
    int          m_k;
    logic [63:0] m_word;
    int          cyc;
    int          obs_hs;
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_word(input int k);
        logic [63:0] w = '0;
        for (int b = 0; b < 64; b++) begin
            if (k * 64 + b < TOTAL) w[b] = bm[k * 64 + b];
        end
        return w;
    endfunction

    function automatic int unsigned late_count();
        int unsigned n = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (bm[i] && set_cyc[i] > snap_cyc[i / 64]) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TOTAL; i++) begin
            bm[i] = 1'b0;
            set_cyc[i] = 0;
        end
        m_count = 0;
        m_oob = 1'b0;
        m_dumping = 1'b0;
        m_k = 0;
        m_word = '0;
    endtask

    task automatic snap();
        m_word = model_word(m_k);
        snap_cyc[m_k] = cyc;
    endtask

    // One clock: drive, advance the model by the spec rules, then compare
    task automatic step(input bit hv, input int hi, input bit req, input bit rdy);
        bit ok, nw, hs;
        hit_valid = hv; hit_index = 14'(hi); dump_req = req; dump_ready = rdy;
        if (dump_valid && rdy) obs_hs++;
        @(posedge clock);
        cyc++;
        ok = hv && hi < TOTAL;
        nw = ok && !bm[hi];
        hs = m_dumping && rdy;
        if (hv && !ok) m_oob = 1'b1;
`ifdef COVER_CLEAR_ON_DUMP_EN
        if (hs) begin
            for (int b = 0; b < 64; b++) begin
                if (m_k * 64 + b < TOTAL && m_word[b]) bm[m_k * 64 + b] = 1'b0;
            end
        end
`endif
        if (ok) bm[hi] = 1'b1;
        if (nw) begin
            set_cyc[hi] = cyc;
            if (m_count != 32'hFFFF_FFFF) m_count++;
        end
        if (hs) begin
            dumped[m_k] = m_word;
            if (m_k == NW - 1) begin
                m_dumping = 1'b0;
`ifdef COVER_CLEAR_ON_DUMP_EN
                m_count = late_count();
`endif
            end else begin
                m_k++;
                snap();
            end
        end else if (!m_dumping && req) begin
            m_dumping = 1'b1;
            m_k = 0;
            snap();
        end
        #1;
        check_eq("dump_valid", 64'(dump_valid), 64'(m_dumping));
        check_eq("busy", 64'(busy), 64'(m_dumping));
        check_eq("new_hit_count", 64'(new_hit_count), 64'(m_count));
        check_eq("oob_err", 64'(oob_err), 64'(m_oob));
        if (m_dumping) begin
            check_eq("dump_addr", 64'(dump_addr), 64'(m_k));
            check_eq("dump_data", dump_data, m_word);
            check_eq("dump_last", 64'(dump_last), 64'(m_k == NW - 1));
        end
    endtask

    task automatic drain_ready();
        for (int i = 0; i < 2000 && m_dumping; i++) step(1'b0, 0, 1'b0, 1'b1);
        if (m_dumping) check_eq("dump_timeout", 64'd1, 64'd0);
    endtask

    task automatic full_dump();
        step(1'b0, 0, 1'b1, 1'b1);
        drain_ready();
    endtask

    function automatic logic [63:0] or_except(input int skip);
        logic [63:0] acc = '0;
        for (int k = 0; k < NW; k++) begin
            if (k != skip) acc = acc | dumped[k];
        end
        return acc;
    endfunction

    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_valid", 64'(dump_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_addr", 64'(dump_addr), 64'd0);
        check_eq("rst_data", dump_data, 64'd0);
        check_eq("rst_last", 64'(dump_last), 64'd0);
        check_eq("rst_count", 64'(new_hit_count), 64'd0);
        check_eq("rst_oob", 64'(oob_err), 64'd0);
        model_reset();
        hit_valid = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; obs_hs = 0;
        model_reset();
        @(posedge clock);
        #1;
        apply_reset();

        // Boundary hits, then a full dump at constant ready
        step(1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 63, 1'b0, 1'b0);
        step(1'b1, 64, 1'b0, 1'b0);
        step(1'b1, 8939, 1'b0, 1'b0);
        check_eq("count_four", 64'(new_hit_count), 64'd4);
        obs_hs = 0;
        full_dump();
        check_eq("word0", dumped[0], 64'h8000_0000_0000_0001);
        check_eq("word1", dumped[1], 64'h1);
        check_eq("word139", dumped[139], 64'h0000_0800_0000_0000);
        check_eq("hs_full", 64'(obs_hs), 64'd140);

        // Repeat hits and an out-of-range index
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 5, 1'b0, 1'b0);
        step(1'b1, 9000, 1'b0, 1'b0);
        check_eq("count_repeat", 64'(new_hit_count), 64'd1);
        check_eq("oob_set", 64'(oob_err), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b0);
        check_eq("oob_sticky", 64'(oob_err), 64'd1);

        // Stall pattern 1-0-0-1 with ignored mid-dump requests
        obs_hs = 0;
        step(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 1000 && m_dumping; i++) step(1'b0, 0, (i % 7) == 3, (i % 4) == 0 || (i % 4) == 3);
        if (m_dumping) check_eq("stall_timeout", 64'd1, 64'd0);
        check_eq("hs_stall", 64'(obs_hs), 64'd140);
        check_eq("bit5_only", dumped[0], 64'h20);
        check_eq("bit5_rest", or_except(0), 64'd0);

        // Hit into the held word after its snapshot
        apply_reset();
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 10 && m_k < 2; i++) step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 130, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        check_eq("held_word2", dump_data, 64'd0);
        drain_ready();
        check_eq("held_count", 64'(new_hit_count), 64'd1);
        full_dump();
        check_eq("second_word2", dumped[2], 64'h4);
        check_eq("second_rest", or_except(2), 64'd0);

        // Hits 0..3 and two back-to-back dumps
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, 1'b0);
        full_dump();
        full_dump();
`ifdef COVER_CLEAR_ON_DUMP_EN
        check_eq("redump_word0", dumped[0], 64'h0);
        check_eq("redump_count", 64'(new_hit_count), 64'd0);
`else
        check_eq("redump_word0", dumped[0], 64'hF);
        check_eq("redump_count", 64'(new_hit_count), 64'd4);
`endif

        // Random traffic
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            int hi;
            hi = ($urandom % 2 == 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 9100));
            step($urandom % 3 != 0, hi, $urandom % 16 == 0, $urandom % 4 != 0);
        end
        drain_ready();

        // Asynchronous reset in the middle of a dump
        step(1'b0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 100 && m_k < 50; i++) step(1'b1, int'($urandom_range(0, 8939)), 1'b0, 1'b1);
        apply_reset();
        full_dump();
        check_eq("post_reset_zero", or_except(-1), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
